// File: rtl/shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// shift_reg_pkg
// Shared definitions for the 4-bit shift register test environment.
// Imported by the stimulus generators, the golden model and the checker.
//   - Mode encodings driven on MODO.
//   - Direction and enable levels.
//   - Checker FSM state encoding.
//   - shift_step(): one clock of shift register behaviour, returned as {so, q}.
// ---------------------------------------------------------------------------
package shift_reg_pkg;

    localparam logic [1:0] SERIAL_SHIFT = 2'b00;
    localparam logic [1:0] CIRC_SHIFT   = 2'b01;
    localparam logic [1:0] PARA_LOAD    = 2'b10;
    localparam logic [1:0] HOLD         = 2'b11;

    localparam logic LOW    = 1'b0;
    localparam logic HIGH   = 1'b1;
    localparam logic ENABLE = 1'b1;

    localparam logic [1:0] ST_UNSYNC = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_FAIL   = 2'd2;

    // Next {so, q} of an enabled shift register. DIR high shifts right
    // (towards bit 0), low shifts left; serial output is the bit that leaves.
    function automatic logic [4:0] shift_step(
        input logic [3:0] q,
        input logic       so,
        input logic       dir,
        input logic       s_in,
        input logic [1:0] modo,
        input logic [3:0] d
    );
        logic [4:0] nxt;
        nxt = {so, q};
        case (modo)
            SERIAL_SHIFT: begin
                if (dir == LOW) nxt = {q[3], q[2:0], s_in};
                else            nxt = {q[0], s_in, q[3:1]};
            end
            CIRC_SHIFT: begin
                if (dir == HIGH) nxt = {q[0], q[0], q[3:1]};
                else             nxt = {q[3], q[2:0], q[3]};
            end
            PARA_LOAD: nxt = {1'b0, d};
            HOLD:      nxt = {so, q};
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/shift_reg_model.sv
// ---------------------------------------------------------------------------
// shift_reg_model
// Cycle-accurate golden 4-bit shift register. Also usable as a DUT stand-in.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en            advance the register this edge (otherwise hold)
//   dir, s_in     shift direction (high = right) and serial input
//   modo, d       mode select and parallel load data
//   q, so         register contents and serial output
// ---------------------------------------------------------------------------
module shift_reg_model
    import shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic       s_in,
    input  logic [1:0] modo,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       so
);

    logic [3:0] reg_q, reg_d;
    logic       so_q, so_d;

    always_comb begin
        {so_d, reg_d} = {so_q, reg_q};
        if (en) begin
            {so_d, reg_d} = shift_step(reg_q, so_q, dir, s_in, modo, d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_q <= 4'b0000;
            so_q  <= 1'b0;
        end else begin
            reg_q <= reg_d;
            so_q  <= so_d;
        end
    end

    assign q  = reg_q;
    assign so = so_q;

endmodule

// File: rtl/shift_reg_checker.sv
// ---------------------------------------------------------------------------
// shift_reg_checker
// Response monitor for the 4-bit shift register. Tracks the stimulus bus with
// a golden model, synchronises on the first enabled parallel load, then
// compares the DUT {S_OUT,Q} against the model on every edge.
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   ENB, DIR, S_IN, MODO, D  stimulus bus shared with the DUT
//   Q, S_OUT               DUT outputs under check
//   SYNCED                 golden model is valid
//   MISMATCH               one-cycle pulse per failing compare
//   FAIL                   sticky, set by the first mismatch
//   ERR_CNT, CHK_CNT       saturating mismatch / compare counters
//   FIRST_EXP, FIRST_GOT   {S_OUT,Q} expected / observed at first mismatch
// ---------------------------------------------------------------------------
module shift_reg_checker
    import shift_reg_pkg::*;
#(
    parameter int ERR_W       = 8,
    parameter int CHK_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODO,
    input  logic [3:0]       D,
    input  logic [3:0]       Q,
    input  logic             S_OUT,
    output logic             SYNCED,
    output logic             MISMATCH,
    output logic             FAIL,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [CHK_W-1:0] CHK_CNT,
    output logic [4:0]       FIRST_EXP,
    output logic [4:0]       FIRST_GOT
);

    logic [3:0] mdl_q;
    logic       mdl_so;
    logic       enabled;
    logic [4:0] exp_snap;
    logic [4:0] got_snap;
    logic       miscompare;

    logic [1:0]       state_q, state_d;
    logic             synced_q, synced_d;
    logic             mismatch_q, mismatch_d;
    logic             fail_q, fail_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [CHK_W-1:0] chk_cnt_q, chk_cnt_d;
    logic [4:0]       first_exp_q, first_exp_d;
    logic [4:0]       first_got_q, first_got_d;

    assign enabled = (ENB == ENABLE);

    // The model free-runs on the stimulus; before sync its contents are
    // simply ignored, and the sync edge is a load that overwrites them.
    shift_reg_model u_model (
        .clk  (CLK),
        .rst  (RST),
        .en   (enabled),
        .dir  (DIR),
        .s_in (S_IN),
        .modo (MODO),
        .d    (D),
        .q    (mdl_q),
        .so   (mdl_so)
    );

    // Case inequality so that X/Z on the DUT outputs is flagged.
    assign exp_snap   = {mdl_so, mdl_q};
    assign got_snap   = {S_OUT, Q};
    assign miscompare = (got_snap !== exp_snap);

    always_comb begin
        state_d     = state_q;
        mismatch_d  = 1'b0;
        fail_d      = fail_q;
        err_cnt_d   = err_cnt_q;
        chk_cnt_d   = chk_cnt_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;

        case (state_q)
            ST_UNSYNC: begin
                if (enabled && (MODO == PARA_LOAD)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (chk_cnt_q != {CHK_W{1'b1}}) begin
                    chk_cnt_d = chk_cnt_q + CHK_W'(1);
                end
                if (miscompare) begin
                    mismatch_d = 1'b1;
                    if (err_cnt_q != {ERR_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    // Only the first failure is captured for post-mortem.
                    if (!fail_q) begin
                        fail_d      = 1'b1;
                        first_exp_d = exp_snap;
                        first_got_d = got_snap;
                    end
                    if (STOP_ON_ERR) begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_UNSYNC;
            end
        endcase

        synced_d = (state_d != ST_UNSYNC);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_UNSYNC;
            synced_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            fail_q      <= 1'b0;
            err_cnt_q   <= '0;
            chk_cnt_q   <= '0;
            first_exp_q <= 5'b0;
            first_got_q <= 5'b0;
        end else begin
            state_q     <= state_d;
            synced_q    <= synced_d;
            mismatch_q  <= mismatch_d;
            fail_q      <= fail_d;
            err_cnt_q   <= err_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
        end
    end

    assign SYNCED    = synced_q;
    assign MISMATCH  = mismatch_q;
    assign FAIL      = fail_q;
    assign ERR_CNT   = err_cnt_q;
    assign CHK_CNT   = chk_cnt_q;
    assign FIRST_EXP = first_exp_q;
    assign FIRST_GOT = first_got_q;

endmodule
